// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: opcode map, port count and
// response-register states.
package alu_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INC = 3'd2,
    ALU_DEC = 3'd3,
    ALU_NOT = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_XOR = 3'd7
  } alu_op_e;

  typedef enum logic {
    RESP_EMPTY = 1'b0,
    RESP_FULL  = 1'b1
  } resp_state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; all results wrap modulo 2^N.
module alu
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  alu_op_e      op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] y_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Opcode decode
  always_comb begin
    y_o = {N{1'b0}};
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_INC: y_o = a_i + ONE;
      ALU_DEC: y_o = a_i - ONE;
      ALU_NOT: y_o = ~a_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Optional zero flag on the response is enabled by defining ALU_ARB_FLAGS_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [2:0]           req_opcode0,
  input  logic [2:0]           req_opcode1,
  input  logic [N-1:0]         req_a0,
  input  logic [N-1:0]         req_a1,
  input  logic [N-1:0]         req_b0,
  input  logic [N-1:0]         req_b1,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [N-1:0]         resp_data,
  output logic                 resp_id
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic                 resp_zero
`endif
);

  resp_state_e  state_q;
  logic [N-1:0] data_q;
  logic         id_q;
  logic         last_q;

  logic         grant_vld;
  logic         grant_id;
  logic         can_accept;
  logic         accept;
  alu_op_e      alu_op;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [N-1:0] alu_y;

  // Round-robin grant: on contention the port not served last wins
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b11: begin
        grant_vld = 1'b1;
        grant_id  = ~last_q;
      end
      2'b01: begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
      default: begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  assign can_accept   = (state_q == RESP_EMPTY) || resp_ready;
  assign req_ready[0] = !reset && can_accept && grant_vld && !grant_id;
  assign req_ready[1] = !reset && can_accept && grant_vld && grant_id;
  assign accept       = |(req_valid & req_ready);

  assign alu_op = grant_id ? alu_op_e'(req_opcode1) : alu_op_e'(req_opcode0);
  assign alu_a  = grant_id ? req_a1 : req_a0;
  assign alu_b  = grant_id ? req_b1 : req_b0;

  alu #(.N(N)) u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

`ifdef ALU_ARB_FLAGS_EN
  logic zero_q;
  assign resp_zero = zero_q;

  // Zero flag tracks the stored result
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b1;
    end else if (accept) begin
      zero_q <= (alu_y == {N{1'b0}});
    end else begin
      zero_q <= zero_q;
    end
  end
`endif

  // Response register state machine; a simultaneous drain and accept reloads
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESP_EMPTY;
      data_q  <= {N{1'b0}};
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        RESP_EMPTY: begin
          if (accept) begin
            state_q <= RESP_FULL;
            data_q  <= alu_y;
            id_q    <= grant_id;
            last_q  <= grant_id;
          end
        end
        RESP_FULL: begin
          if (accept) begin
            data_q  <= alu_y;
            id_q    <= grant_id;
            last_q  <= grant_id;
          end else if (resp_ready) begin
            state_q <= RESP_EMPTY;
          end
        end
        default: state_q <= RESP_EMPTY;
      endcase
    end
  end

  assign resp_valid = (state_q == RESP_FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one N-bit `alu` instance between two independent requesters (port 0, port 1). Uses a valid/ready request handshake on each port and a single registered response channel tagged with the winning port ID. Grants are round-robin, so neither requester can starve the other. Sits between the datapath front ends and the combinational ALU; the ALU opcode map is unchanged.

## Interface
- `N`, 4: operand/result width in bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-port request valid; bit i = port i.
- `req_ready`  out  2  per-port accept; a transfer occurs on port i when `req_valid[i] && req_ready[i]` at a rising edge.
- `req_opcode0`, `req_opcode1`  in  3  ALU opcode per port: 0 add, 1 sub, 2 inc, 3 dec, 4 not A, 5 and, 6 or, 7 xor.
- `req_a0`, `req_a1`  in  N  operand A per port.
- `req_b0`, `req_b1`  in  N  operand B per port.
- `resp_valid`  out  1  response register holds a result.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_data`  out  N  ALU result, truncated to N bits.
- `resp_id`  out  1  port that issued the result.
- `resp_zero`  out  1  `resp_data == 0` (only with `ALU_ARB_FLAGS_EN`).

## Operation
- Response register: two states, EMPTY and FULL.
  - EMPTY→FULL on an accepted request with no drain.
  - FULL→EMPTY on `resp_ready` with no new accept.
  - FULL→FULL on a simultaneous drain and accept; the register reloads.
- `can_accept = !resp_valid || resp_ready`.
- Priority pointer `last` (1 bit) holds the port granted most recently.
- Grant rules:
  - If both ports are valid, grant goes to `~last`.
  - If one port is valid, that port is granted.
  - If no port is valid, there is no grant.
- `req_ready[i] = can_accept && grant == i`. At most one bit is set. `req_ready` never depends on the other port's ready.
- On accept: the selected operands and opcode drive the ALU. The result loads `resp_data`, the port loads `resp_id`, and `last` updates to the granted port.
- Arithmetic wraps modulo 2^N. Examples: 4'hF+1 = 0, 0-1 = 4'hF. No carry or overflow output.
- Requesters must hold `req_*` stable while valid and not ready. The block does not check this.
- `resp_data` and `resp_id` are held stable while `resp_valid && !resp_ready`.

## Timing
- Reset values:
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `resp_zero` = 1.
  - `last` = 1, so port 0 wins the first contention.
- Reset takes priority over every handshake. An in-flight response is discarded, and `req_ready` is 0 during any cycle in which `reset` is high.
- Latency: accept at edge k gives `resp_valid` = 1 after edge k, i.e. result visible in cycle k+1.
- Throughput: one op per cycle while `resp_ready` is held high.
- `req_ready` is combinational from `req_valid`, `resp_valid`, `resp_ready` and `last`. There is no combinational path from `req_opcode*` or `req_a*`/`req_b*` to any output.

## Configuration
- `ALU_ARB_FLAGS_EN` defined:
  - `resp_zero` port exists.
  - It is registered alongside `resp_data` and is 1 exactly when the stored result is 0.
- `ALU_ARB_FLAGS_EN` undefined:
  - The port is absent.
  - The block has no flag logic.

## Structure
- Shared package `alu_pkg`:
  - `typedef enum logic [2:0]` for the opcode (ADD, SUB, INC, DEC, NOT, AND, OR, XOR).
  - `localparam NUM_PORTS = 2`.
  - Enum for the response-register state (EMPTY, FULL).
- Sub-module: one instance of the existing `alu`, parameterised with `N`. The arbiter adds no arithmetic of its own. Round-robin grant logic stays inline.

## Test plan
- Reset, then port 0 requests opcode 0, A=3, B=4, with `resp_ready` = 1:
  - `req_ready` = 2'b01.
  - Next cycle: `resp_valid` = 1, `resp_data` = 7, `resp_id` = 0.
- Both ports valid for 4 cycles with `resp_ready` = 1:
  - Grants alternate 0,1,0,1.
  - Port 0 sends opcode 1, 5, 2 → 3. Port 1 sends opcode 7, 4'hA, 4'h5 → 4'hF.
- Backpressure: `resp_ready` = 0 with port 1 holding opcode 3, A=0:
  - Result 4'hF is held for 3 cycles.
  - `req_ready` = 0 while full.
  - Drain and new accept in the same cycle reload correctly.
- Wrap-around cases:
  - Opcode 2, A=4'hF → 0; `resp_zero` = 1 with the macro.
  - Opcode 4, A=4'h0 → 4'hF.
- Assert `reset` while `resp_valid` = 1 and both ports are valid:
  - Next cycle `resp_valid` = 0 and no grant is recorded.
  - First post-reset contention grants port 0.
- Random valid/ready traffic for 10k cycles:
  - Scoreboard matches every result and ID in order.
  - Neither port waits more than 2 accepts.
